// File: rtl/music_seq_ctrl.sv
// music_seq_ctrl
// Playback controller for the song ROM tables. It walks a beat index through
// one song pass at a selectable tempo. It reacts to debounced one-cycle
// button pulses for play/pause, stop and song select.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   play_pulse  one-cycle pulse: play/pause toggle
//   stop_pulse  one-cycle pulse: stop and rewind
//   sel_pulse   one-cycle pulse: toggle song/part select and rewind
//   loop_en     1 = wrap at end of song, 0 = one-shot
//   speed       tempo: 0=1x, 1=2x, 2=4x, 3=8x
//   beat_num    beat index to the tone tables
//   song_en     song/part select to the tone tables
//   mute        1 = speaker output forced silent
//   playing     1 while in PLAY
//   done_pulse  one-cycle pulse when a one-shot pass completes
//
// Parameter limits: BEAT_LEN <= 4096 and TICK_DIV >= 8.
module music_seq_ctrl #(
  parameter int TICK_DIV = 6250000,
  parameter int BEAT_LEN = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play_pulse,
  input  logic        stop_pulse,
  input  logic        sel_pulse,
  input  logic        loop_en,
  input  logic [1:0]  speed,
  output logic [11:0] beat_num,
  output logic        song_en,
  output logic        mute,
  output logic        playing,
  output logic        done_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] TICK_DIV_W = 32'(TICK_DIV);
  localparam logic [11:0] LAST_BEAT  = 12'(BEAT_LEN - 1);

  state_t      state_reg, state_next;
  logic [11:0] beat_reg, beat_next;
  logic [31:0] tick_reg, tick_next;
  logic        song_reg, song_next;
  logic        done_reg, done_next;
  logic        mute_reg, playing_reg;

  logic [31:0] div_lim;
  logic        step;

  // The >= compare lets a mid-step tempo increase end the current step on
  // the next cycle. An == compare would have to count through a full
  // 32-bit wrap instead.
  assign div_lim = (TICK_DIV_W >> speed) - 32'd1;
  assign step    = (state_reg == PLAY) && (tick_reg >= div_lim);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      beat_reg    <= 12'd0;
      tick_reg    <= 32'd0;
      song_reg    <= 1'b1;
      done_reg    <= 1'b0;
      mute_reg    <= 1'b1;
      playing_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      beat_reg    <= beat_next;
      tick_reg    <= tick_next;
      song_reg    <= song_next;
      done_reg    <= done_next;
      // Status flags are registered from the next state so they line up with
      // state_reg without a combinational decode on the outputs.
      mute_reg    <= (state_next != PLAY);
      playing_reg <= (state_next == PLAY);
    end
  end

  // Priority per cycle: stop > play > sel > step. A step that coincides with
  // play or sel is dropped because those branches never look at it.
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    tick_next  = tick_reg;
    song_next  = song_reg;
    done_next  = 1'b0;

    if (stop_pulse) begin
      state_next = IDLE;
      beat_next  = 12'd0;
      tick_next  = 32'd0;
    end else if (play_pulse) begin
      case (state_reg)
        IDLE:    state_next = PLAY;
        PLAY:    state_next = PAUSE;  // beat and tick are frozen as they are
        PAUSE:   state_next = PLAY;   // resume at the held position
        DONE: begin
          state_next = PLAY;
          beat_next  = 12'd0;
          tick_next  = 32'd0;
        end
        default: state_next = IDLE;
      endcase
    end else if (sel_pulse) begin
      song_next = ~song_reg;
      beat_next = 12'd0;
      tick_next = 32'd0;
      if (state_reg == DONE) begin
        state_next = IDLE;
      end
    end else if (state_reg == PLAY) begin
      if (step) begin
        tick_next = 32'd0;
        if (beat_reg < LAST_BEAT) begin
          beat_next = beat_reg + 12'd1;
        end else if (loop_en) begin
          beat_next = 12'd0;
        end else begin
          beat_next  = 12'd0;
          state_next = DONE;
          done_next  = 1'b1;
        end
      end else begin
        tick_next = tick_reg + 32'd1;
      end
    end
  end

  assign beat_num   = beat_reg;
  assign song_en    = song_reg;
  assign mute       = mute_reg;
  assign playing    = playing_reg;
  assign done_pulse = done_reg;

endmodule

// File: doc/music_seq_ctrl.md
Name: music_seq_ctrl

Overview:
- Playback controller that sequences the song ROM tables by generating the beat index they decode.
- Fed by debounced, one-pulse button events (play/pause, stop, song select).
- Outputs: beat index, song/part select, mute and status.
- Sits between the button conditioning logic and the tone tables / speaker PWM divider.

Parameters:
- TICK_DIV, 6250000: clock cycles per beat-index step at 1x speed (16 steps/s at 100 MHz).
- BEAT_LEN, 128: number of beat indices in one song pass; index runs 0..BEAT_LEN-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- play_pulse  in  1  one-cycle pulse; play/pause toggle
- stop_pulse  in  1  one-cycle pulse; stop and rewind
- sel_pulse  in  1  one-cycle pulse; toggle song/part select and rewind
- loop_en  in  1  1 = wrap at end of song, 0 = one-shot
- speed  in  2  tempo: 0=1x, 1=2x, 2=4x, 3=8x
- beat_num  out  12  beat index to tone tables
- song_en  out  1  song/part select to tone tables
- mute  out  1  1 = speaker output forced silent
- playing  out  1  1 while in PLAY
- done_pulse  out  1  one-cycle pulse on one-shot completion

Behaviour:
- Reset values (rst sampled on clk rising edge):
  - state IDLE, beat_num=0, tick_cnt=0, song_en=1.
  - mute=1, playing=0, done_pulse=0.
  - rst asserted mid-playback has the same effect.
- States and outputs:
  - IDLE (stopped at 0): mute=1, playing=0.
  - PLAY: mute=0, playing=1.
  - PAUSE (position held): mute=1, playing=0.
  - DONE (one-shot finished): mute=1, playing=0.
- Tick divider:
  - div_lim = (TICK_DIV >> speed) - 1.
  - In PLAY, tick_cnt increments each cycle.
  - When tick_cnt >= div_lim: tick_cnt <= 0 and step fires.
  - The >= compare makes a speed increase mid-step end the step on the next cycle, with no long wrap.
  - tick_cnt holds in PAUSE and is 0 in IDLE/DONE.
- Step in PLAY:
  - If beat_num < BEAT_LEN-1: beat_num+1.
  - Else if loop_en=1: beat_num <= 0, stay in PLAY.
  - Else: beat_num <= 0, go to DONE, done_pulse=1 for exactly that cycle.
- Transitions (priority per cycle: stop > play > sel > step):
  - stop_pulse in any state -> IDLE, beat_num=0, tick_cnt=0.
  - play_pulse: IDLE -> PLAY; PLAY -> PAUSE; PAUSE -> PLAY (resumes same beat_num and tick_cnt); DONE -> PLAY from 0.
  - sel_pulse: song_en toggles, beat_num=0, tick_cnt=0.
    - PLAY stays PLAY; PAUSE stays PAUSE; DONE -> IDLE; IDLE stays IDLE.
  - A step coinciding with play_pulse in PLAY is discarded: go to PAUSE, beat_num unchanged.
  - A step coinciding with sel_pulse is discarded: sel rewind wins.
- Output timing: all outputs are registered; beat_num changes the cycle after the step condition.
- Width rules:
  - beat_num is 12-bit; BEAT_LEN must be ≤ 4096.
  - TICK_DIV must be ≥ 8 so div_lim ≥ 0 at 8x.
  - The tick counter is 32-bit.

Test Plan (TICK_DIV=8, BEAT_LEN=4 unless noted):
- Reset, then play_pulse, loop_en=1, speed=0 -> beat_num sequence 0,1,2,3,0,1 with each value held 8 cycles; mute=0 and playing=1 from the cycle after the pulse.
- loop_en=0, play, run 32 cycles -> done_pulse high for exactly 1 cycle as beat_num goes 3->0; state DONE, mute=1; a later play_pulse restarts at beat 0.
- Play; at beat_num=2 with tick_cnt=5, play_pulse -> PAUSE, values frozen for 20 cycles, mute=1; play_pulse again -> beat 3 is reached 3 cycles later.
- speed=3 (div_lim=0) -> beat_num advances every cycle. Switching speed 0->2 while tick_cnt=6 -> step on the next cycle, then steps every 2 cycles.
- During PLAY at beat 2: sel_pulse -> song_en 1->0, beat_num=0, still PLAY. The same cycle carrying stop_pulse+play_pulse+sel_pulse -> IDLE, song_en unchanged.
- rst asserted for 1 cycle while PLAY at beat 3 -> next cycle beat_num=0, song_en=1, mute=1, playing=0, IDLE.
